// File: rtl/mio_pkg.sv
// Shared types and default sizing for the data-memory/IO bus bridge.
package mio_pkg;

    localparam int          MIO_ADDR_W         = 32;
    localparam int          MIO_DATA_W         = 32;
    localparam int unsigned MIO_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mio_state_e;

endpackage

// File: rtl/mio_bus_bridge_if.sv
// CPU load/store port and memory req/ack bus as seen by the bridge.
interface mio_bus_bridge_if
    import mio_pkg::*;
#(
    parameter int ADDR_W = MIO_ADDR_W,
    parameter int DATA_W = MIO_DATA_W
);
    logic              cpu_mio;
    logic              cpu_memrw;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mio_ready;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              bus_err;

    // bridge side
    modport slave (
        input  cpu_mio, cpu_memrw, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, mio_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    // CPU core plus memory, i.e. everything around the bridge
    modport master (
        output cpu_mio, cpu_memrw, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, mio_ready, mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

endinterface

// File: rtl/mio_timeout_counter.sv
// REQ-phase watchdog: down-counter that reaches terminal count on the
// TIMEOUT_CYCLES-th enabled REQ cycle.
module mio_timeout_counter
    import mio_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MIO_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    // Loaded with N-1 so terminal count coincides with the Nth REQ cycle.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/mio_bus_bridge.sv
// Stalls the single-cycle core while a load/store runs a req/ack handshake.
// Optional REQ watchdog with sticky bus_err enabled by defining MIO_TIMEOUT_EN.
module mio_bus_bridge
    import mio_pkg::*;
#(
    parameter int          ADDR_W         = MIO_ADDR_W,
    parameter int          DATA_W         = MIO_DATA_W,
    parameter int unsigned TIMEOUT_CYCLES = MIO_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    mio_bus_bridge_if.slave    bus
);

    mio_state_e        state;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              to_expired;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("mio_bus_bridge: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef MIO_TIMEOUT_EN
    mio_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != ST_REQ),
        .en      ((state == ST_REQ) && !bus.mem_ack),
        .expired (to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.cpu_mio) begin
                        addr_q  <= bus.cpu_addr;
                        wdata_q <= bus.cpu_wdata;
                        we_q    <= bus.cpu_memrw;
                        req_q   <= 1'b1;
                        state   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A real ack always beats the watchdog on the same cycle.
                    if (bus.mem_ack) begin
                        if (!we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        req_q <= 1'b0;
                        state <= ST_DONE;
                    end else if (to_expired) begin
                        if (!we_q) begin
                            rdata_q <= '0;
                        end
                        err_q <= 1'b1;
                        req_q <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    req_q <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bus.mio_ready = 1'b0;
        case (state)
            ST_IDLE: bus.mio_ready = !bus.cpu_mio;
            ST_DONE: bus.mio_ready = 1'b1;
            default: bus.mio_ready = 1'b0;
        endcase
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.cpu_rdata = rdata_q;

`ifdef MIO_TIMEOUT_EN
    assign bus.bus_err = err_q;
`else
    assign bus.bus_err = 1'b0;
`endif

endmodule

// File: doc/mio_bus_bridge.md
# mio_bus_bridge

Data-memory/IO bus bridge sitting directly downstream of the single-cycle CPU core's load/store port. It captures the CPU's address, write data and direction when the CPU raises its memory/IO request, runs a req/ack handshake with a variable-latency memory, and holds the CPU stalled by driving `mio_ready` low until the access completes. Read data is registered and returned to the core's data input.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT_CYCLES`, 255: REQ cycles without ack before abort; used only with the timeout feature.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `cpu_mio` input 1: CPU memory/IO access request, level; held until `mio_ready` is high.
- `cpu_memrw` input 1: 1 = store, 0 = load.
- `cpu_addr` input ADDR_W: access address.
- `cpu_wdata` input DATA_W: store data.
- `cpu_rdata` output DATA_W: registered load data to the CPU.
- `mio_ready` output 1: access complete / no stall.
- `mem_req` output 1: memory request, held high until ack.
- `mem_we` output 1: memory write enable.
- `mem_addr` output ADDR_W: latched address.
- `mem_wdata` output DATA_W: latched store data.
- `mem_rdata` input DATA_W: memory read data, valid with `mem_ack`.
- `mem_ack` input 1: memory completion, one cycle.
- `bus_err` output 1: sticky timeout flag.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: `mio_ready` = !`cpu_mio`. If `cpu_mio`=1, latch `cpu_addr`, `cpu_wdata`, `cpu_memrw` into `mem_addr`/`mem_wdata`/`mem_we`; go to REQ.
- REQ: `mem_req`=1, memory outputs stable. On `mem_ack`=1: for loads, latch `mem_rdata` into `cpu_rdata`; go to DONE. Otherwise stay.
- DONE: `mem_req`=0, `mio_ready`=1 for exactly one cycle; go to IDLE unconditionally. The CPU retires its instruction on this edge.
- Stores leave `cpu_rdata` unchanged.
- `mem_ack` outside REQ is ignored.
- CPU inputs are sampled only in IDLE. Changes during REQ/DONE have no effect.
- Back-to-back accesses: a new `cpu_mio` seen in IDLE the cycle after DONE starts a new request. There is no IDLE→REQ bypass.

## Timing
- Reset values:
  - state = IDLE.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `cpu_rdata`=0, `bus_err`=0.
  - `mio_ready` follows IDLE rule (=!`cpu_mio`).
- Minimum latency: request seen in IDLE at cycle 0, `mem_req` high in cycle 1, ack in cycle 1, `mio_ready` high in cycle 2.
- Each wait cycle without ack adds one cycle.
- `mem_req` deasserts on the edge where ack is sampled.
- All outputs except `mio_ready` are registered. `mio_ready` is decoded from state and `cpu_mio`.
- Reset mid-REQ: the next edge returns to IDLE with `mem_req`=0. An in-flight ack on that edge is discarded.
- Reset has priority over ack and timeout on the same edge.

## Configuration
- `MIO_TIMEOUT_EN` defined:
  - A counter clears on REQ entry and increments each REQ cycle without ack.
  - When it equals `TIMEOUT_CYCLES` with no ack: go to DONE, load `cpu_rdata`=0 (loads), set `bus_err`=1. `bus_err` clears only on reset.
  - An ack on the timeout cycle wins: normal completion, no error.
- `MIO_TIMEOUT_EN` undefined: no counter, `bus_err` tied 0, REQ waits indefinitely.

## Structure
- Package `mio_pkg`: state enum (IDLE/REQ/DONE), default widths, `TIMEOUT_CYCLES` default.
- Sub-module `mio_timeout_counter`: width $clog2(TIMEOUT_CYCLES+1); inputs clr/en; output expired. Instantiated only under `MIO_TIMEOUT_EN`.

## Test plan
- Load, ack in first REQ cycle: addr 0x0000_0010, `mem_rdata` 0x1234_5678 → `mem_req` high cycle 1 only, `mio_ready` high cycle 2, `cpu_rdata`=0x1234_5678.
- Store, ack after 4 wait cycles: addr 0x0000_0020, wdata 0xCAFE_F00D → `mem_we`=1, address/data stable 5 cycles, `mio_ready` in cycle 6, `cpu_rdata` unchanged.
- No access: `cpu_mio`=0 for 10 cycles → `mio_ready`=1 throughout; `mem_req`=0; spurious `mem_ack` ignored.
- Back-to-back load then store → second `mem_req` rises exactly 2 cycles after first DONE cycle.
- Reset asserted in 2nd REQ cycle with `mem_ack`=1 → next cycle IDLE, `mem_req`=0, `cpu_rdata`=0.
- With `MIO_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, no ack → DONE after 8 REQ cycles, `cpu_rdata`=0, `bus_err`=1 until reset. A repeat with ack on the 8th cycle completes normally, `bus_err` stays 0.
